// File: rtl/vector_mask_result_packer_pkg.sv
// Shared vector-unit constants plus the mask packer's state type and element-count helper.
// Both packages live together so a single file brings in everything the packer needs.
package riscv_v_pkg;
  localparam int VLEN = 128;
endpackage

package dragonfang_pkg;
  import riscv_v_pkg::*;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } mask_packer_state_t;

  // Number of mask bits one vector register contributes at the given vsew.
  function automatic int elements_per_register(input logic [1:0] vsew);
    return VLEN >> (3 + int'(vsew));
  endfunction
endpackage

// File: rtl/vector_mask_result_packer_if.sv
// Start / fragment / packed-mask handshakes between compare unit, packer and writeback.
// The master side drives requests and fragments; the slave side is the packer.
interface vector_mask_result_packer_if #(
  parameter int VLEN = riscv_v_pkg::VLEN
);
  localparam int VLW = $clog2(VLEN) + 1;

  logic            start_valid;
  logic            start_ready;
  logic [1:0]      start_sew;
  logic [1:0]      start_lmul;
  logic [VLW-1:0]  start_vl;
  logic            part_valid;
  logic            part_ready;
  logic [VLEN-1:0] part_mask;
  logic            mask_valid;
  logic            mask_ready;
  logic [VLEN-1:0] mask_data;

  modport master (
    output start_valid, start_sew, start_lmul, start_vl,
    output part_valid, part_mask, mask_ready,
    input  start_ready, part_ready, mask_valid, mask_data
  );

  modport slave (
    input  start_valid, start_sew, start_lmul, start_vl,
    input  part_valid, part_mask, mask_ready,
    output start_ready, part_ready, mask_valid, mask_data
  );
endinterface

// File: rtl/vector_mask_tail_clear.sv
// Combinational keep mask for the vl tail: bit e is set when e < vl.
// A shift by vl >= VLEN yields zero, so vl = VLEN gives an all-ones keep mask.
module vector_mask_tail_clear #(
  parameter int VLEN = riscv_v_pkg::VLEN,
  localparam int VLW = $clog2(VLEN) + 1
) (
  input  logic [VLW-1:0]  vl,
  output logic [VLEN-1:0] keep
);
  assign keep = ~({VLEN{1'b1}} << vl);
endmodule

// File: rtl/vector_mask_result_packer.sv
// Packs 2^lmul per-register compare fragments into one tail-cleared VLEN-bit mask.
// Mask valid 2^lmul+1 cycles after start when unstalled; held until writeback accepts it.
module vector_mask_result_packer
  import dragonfang_pkg::*;
#(
  parameter int VLEN = riscv_v_pkg::VLEN,
  localparam int VLW = $clog2(VLEN) + 1
) (
  input  logic                         clock,
  input  logic                         reset,
  vector_mask_result_packer_if.slave   bus,
  output logic                         busy
);

  mask_packer_state_t state_q, state_nxt;

  logic [1:0]      sew_q;
  logic [1:0]      lmul_q;
  logic [VLW-1:0]  vl_q;
  logic [2:0]      pass_q;
  logic [VLEN-1:0] acc_q;
  logic [VLEN-1:0] acc_nxt;
  logic [VLEN-1:0] mask_data_q;
  logic [VLEN-1:0] keep;
  logic [2:0]      pass_last;
  logic            start_fire;
  logic            part_fire;
  logic            mask_fire;
  logic            last_pass;

  vector_mask_tail_clear #(.VLEN(VLEN)) u_tail_clear (
    .vl   (vl_q),
    .keep (keep)
  );

  assign pass_last = 3'((4'd1 << lmul_q) - 4'd1);
  assign last_pass = (pass_q == pass_last);

  // Handshake outputs come from the state register only.
  always_comb begin
    state_nxt       = state_q;
    bus.start_ready = (state_q == IDLE);
    bus.part_ready  = (state_q == COLLECT);
    bus.mask_valid  = (state_q == DONE);
    busy            = (state_q != IDLE);
    start_fire      = bus.start_valid && (state_q == IDLE);
    part_fire       = bus.part_valid  && (state_q == COLLECT);
    mask_fire       = bus.mask_ready  && (state_q == DONE);
    case (state_q)
      IDLE:    if (start_fire) state_nxt = COLLECT;
      COLLECT: if (part_fire && last_pass) state_nxt = DONE;
      DONE:    if (mask_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Splice the low epr bits of the fragment into the accumulator at pass*epr.
  always_comb begin
    int epr;
    int base;
    logic [VLEN-1:0] low;
    epr     = elements_per_register(sew_q);
    base    = int'(pass_q) * epr;
    low     = {VLEN{1'b1}} >> (VLEN - epr);
    acc_nxt = (acc_q & ~(low << base)) | ((bus.part_mask & low) << base);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sew_q       <= '0;
      lmul_q      <= '0;
      vl_q        <= '0;
      pass_q      <= '0;
      acc_q       <= '0;
      mask_data_q <= '0;
    end else begin
      if (start_fire) begin
        sew_q  <= bus.start_sew;
        lmul_q <= bus.start_lmul;
        vl_q   <= bus.start_vl;
        acc_q  <= '0;
        pass_q <= '0;
      end
      if (part_fire) begin
        acc_q  <= acc_nxt;
        pass_q <= pass_q + 3'd1;
        if (last_pass) begin
          mask_data_q <= acc_nxt & keep;
        end
      end
    end
  end

  assign bus.mask_data = mask_data_q;

endmodule
